// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the controller (master)
// drives start and operands, the subtractor (slave) returns the result and status.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] bw;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (output start, a, b, bin, input diff, bw, bout, busy, done);
  modport slave  (input start, a, b, bin, output diff, bw, bout, busy, done);
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock,
// LSB first, exposing the per-bit borrow chain. Results update atomically on done.
module srs_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_ripple_subtractor_if.slave   io
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dacc_q, dacc_d, bacc_q, bacc_d;
  logic [WIDTH-1:0] diff_q, diff_d, bw_q, bw_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             bit_d, bit_bo;

  srs_bit_cell u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    dacc_d  = dacc_q;
    bacc_d  = bacc_q;
    diff_d  = diff_q;
    bw_d    = bw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts like IDLE so back-to-back ops need no idle gap
        if (io.start) begin
          state_d = RUN;
          a_sh_d  = io.a;
          b_sh_d  = io.b;
          br_d    = io.bin;
          cnt_d   = '0;
          dacc_d  = '0;
          bacc_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        dacc_d[cnt_q] = bit_d;
        bacc_d[cnt_q] = bit_bo;
        br_d          = bit_bo;
        a_sh_d        = a_sh_q >> 1;
        b_sh_d        = b_sh_q >> 1;
        cnt_d         = cnt_q + IW'(1);
        if (cnt_q == IW'(WIDTH - 1)) begin
          // publish the full word in one edge so no partial result is seen
          diff_d  = dacc_d;
          bw_d    = bacc_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      dacc_q  <= '0;
      bacc_q  <= '0;
      diff_q  <= '0;
      bw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      dacc_q  <= dacc_d;
      bacc_q  <= bacc_d;
      diff_q  <= diff_d;
      bw_q    <= bw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.diff = diff_q;
  assign io.bw   = bw_q;
  assign io.bout = bw_q[WIDTH-1];
  assign io.busy = busy_q;
  assign io.done = done_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor at WIDTH=4 and WIDTH=8:
// expected results are queued at drive time and popped on each done pulse.
module tb_serial_ripple_subtractor;
  localparam int W4 = 4;
  localparam int W8 = 8;

  typedef struct packed {
    logic [31:0] diff;
    logic [31:0] bw;
    logic        bout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q4[$];
  exp_t q8[$];
  logic [31:0] hold4, hold8;
  int   bc4, bc8;

  serial_ripple_subtractor_if #(.WIDTH(W4)) io4 ();
  serial_ripple_subtractor_if #(.WIDTH(W8)) io8 ();

  serial_ripple_subtractor #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .io(io4));
  serial_ripple_subtractor #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .io(io8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bin);
    exp_t   r;
    longint m, mi;
    m      = (longint'(1) << w) - 1;
    r.diff = 32'((longint'(a) - longint'(b) - longint'(bin)) & m);
    r.bout = (longint'(a) < longint'(b) + longint'(bin));
    r.bw   = '0;
    for (int i = 0; i < w; i++) begin
      mi      = (longint'(1) << (i + 1)) - 1;
      r.bw[i] = ((longint'(a) & mi) < (longint'(b) & mi) + longint'(bin));
    end
    return r;
  endfunction

  // Result monitors: scoreboard pop, busy width, bout/bw tie, diff hold between dones
  always @(negedge clk) begin
    if (!rst_n) begin
      hold4 <= '0;
      bc4   <= 0;
    end else begin
      if (io4.busy) bc4 <= bc4 + 1;
      if (io4.done) begin
        chk("busy4_width", bc4, W4);
        chk("bout4_eq_bw", io4.bout, io4.bw[W4-1]);
        chk("busy4_low_on_done", io4.busy, 1'b0);
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          chk("diff4", io4.diff, q4[0].diff);
          chk("bw4", io4.bw, q4[0].bw);
          chk("bout4", io4.bout, q4[0].bout);
          void'(q4.pop_front());
        end
        bc4   <= 0;
        hold4 <= 32'(io4.diff);
      end else chk("diff4_hold", io4.diff, hold4);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold8 <= '0;
      bc8   <= 0;
    end else begin
      if (io8.busy) bc8 <= bc8 + 1;
      if (io8.done) begin
        chk("busy8_width", bc8, W8);
        chk("bout8_eq_bw", io8.bout, io8.bw[W8-1]);
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          chk("diff8", io8.diff, q8[0].diff);
          chk("bw8", io8.bw, q8[0].bw);
          chk("bout8", io8.bout, q8[0].bout);
          void'(q8.pop_front());
        end
        bc8   <= 0;
        hold8 <= 32'(io8.diff);
      end else chk("diff8_hold", io8.diff, hold8);
    end
  end

  // Drive one start pulse; returns one tick after the accepting edge.
  task automatic go(input bit d4, input bit d8, input logic [31:0] a, input logic [31:0] b,
                    input logic bin);
    @(posedge clk); #1;
    if (d4) begin
      io4.start = 1'b1; io4.a = a[W4-1:0]; io4.b = b[W4-1:0]; io4.bin = bin;
      q4.push_back(ref_sub(W4, a & 32'hF, b & 32'hF, bin));
    end
    if (d8) begin
      io8.start = 1'b1; io8.a = a[W8-1:0]; io8.b = b[W8-1:0]; io8.bin = bin;
      q8.push_back(ref_sub(W8, a & 32'hFF, b & 32'hFF, bin));
    end
    @(posedge clk); #1;
    io4.start = 1'b0;
    io8.start = 1'b0;
  endtask

  task automatic wait_done(input bit w8, output int t);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (w8 ? io8.done : io4.done) begin
        t = cyc;
        return;
      end
    end
    chk("done_timeout", 0, 1);
    t = cyc;
  endtask

  initial begin
    int t0, t1, t2;
    logic [31:0] ra, rb;
    logic        rbin;
    rst_n = 1'b0;
    io4.start = 1'b0; io4.a = '0; io4.b = '0; io4.bin = 1'b0;
    io8.start = 1'b0; io8.a = '0; io8.b = '0; io8.bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_diff", io4.diff, 0);
    chk("rst_bw", io4.bw, 0);
    chk("rst_bout", io4.bout, 0);
    chk("rst_busy", io4.busy, 0);
    chk("rst_done", io4.done, 0);
    chk("rst8_diff", io8.diff, 0);
    rst_n = 1'b1;

    // Basic 9-3 with an ignored start carrying different operands mid-RUN
    go(1, 0, 9, 3, 0);
    t0 = cyc;
    chk("basic_busy", io4.busy, 1);
    @(posedge clk); #1;
    io4.start = 1'b1; io4.a = 4'd5; io4.b = 4'd1; io4.bin = 1'b1;
    @(posedge clk); #1;
    io4.start = 1'b0; io4.a = 4'd2; io4.b = 4'd7;
    wait_done(0, t1);
    chk("basic_latency", t1 - t0, W4);
    chk("basic_diff", io4.diff, 4'b0110);
    chk("basic_bw", io4.bw, 4'b0110);
    chk("basic_bout", io4.bout, 0);

    // Back-to-back: 15-15 accepted in the DONE cycle
    io4.start = 1'b1; io4.a = 4'd15; io4.b = 4'd15; io4.bin = 1'b0;
    q4.push_back(ref_sub(W4, 15, 15, 0));
    @(posedge clk); #1;
    io4.start = 1'b0;
    chk("b2b_busy", io4.busy, 1);
    chk("b2b_done_low", io4.done, 0);
    wait_done(0, t2);
    chk("b2b_spacing", t2 - t1, W4 + 1);
    chk("b2b_diff", io4.diff, 0);
    chk("b2b_bw", io4.bw, 0);
    chk("b2b_bout", io4.bout, 0);

    // Underflow and full borrow ripple
    go(1, 0, 3, 9, 0);
    wait_done(0, t1);
    chk("uf_diff", io4.diff, 4'b1010);
    chk("uf_bw", io4.bw, 4'b1000);
    chk("uf_bout", io4.bout, 1);
    go(1, 0, 0, 0, 1);
    wait_done(0, t1);
    chk("ripple_diff", io4.diff, 4'b1111);
    chk("ripple_bw", io4.bw, 4'b1111);
    chk("ripple_bout", io4.bout, 1);

    // Reset mid-RUN: async clear, no done, then a fresh operation
    go(1, 0, 9, 3, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_diff", io4.diff, 0);
    chk("arst_bw", io4.bw, 0);
    chk("arst_bout", io4.bout, 0);
    chk("arst_busy", io4.busy, 0);
    chk("arst_done", io4.done, 0);
    q4.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", io4.done, 0);
    end
    go(1, 0, 12, 5, 1);
    t0 = cyc;
    wait_done(0, t1);
    chk("post_rst_latency", t1 - t0, W4);
    chk("post_rst_diff", io4.diff, 4'd6);

    // Random operands on both widths in parallel
    for (int n = 0; n < 1000; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      go(1, 1, ra, rb, rbin);
      wait_done(1, t1);
    end
    @(posedge clk); #1;
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
